// File: rtl/pipe_pkg.sv
// Shared datapath field widths, stage control bundles and NOP control words.
// Used by pipe_stage_reg and the per-stage wrappers that instantiate it.
package pipe_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_CTRL_W = 6;
  localparam int unsigned EX_CTRL_W  = 7;
  localparam int unsigned MEM_CTRL_W = 5;
  localparam int unsigned WR_CTRL_W  = 2;

  // ID/EX carries PC+4, immediate, busA and busB.
  localparam int unsigned ID_EX_DATA_W  = 4 * WORD_W;
  localparam int unsigned ID_EX_CTRL_W  = REG_ADDR_W + ALU_CTRL_W + EX_CTRL_W
                                        + MEM_CTRL_W + WR_CTRL_W;
  localparam int unsigned EX_MEM_CTRL_W = REG_ADDR_W + MEM_CTRL_W + WR_CTRL_W;
  localparam int unsigned MEM_WB_CTRL_W = REG_ADDR_W + WR_CTRL_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rw;
    logic [ALU_CTRL_W-1:0] alu;
    logic [EX_CTRL_W-1:0]  ex;
    logic [MEM_CTRL_W-1:0] mem;
    logic [WR_CTRL_W-1:0]  wr;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rw;
    logic [MEM_CTRL_W-1:0] mem;
    logic [WR_CTRL_W-1:0]  wr;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rw;
    logic [WR_CTRL_W-1:0]  wr;
  } mem_wb_ctrl_t;

  // All-zero control words write nothing and touch no memory.
  localparam id_ex_ctrl_t  ID_EX_NOP  = '0;
  localparam ex_mem_ctrl_t EX_MEM_NOP = '0;
  localparam mem_wb_ctrl_t MEM_WB_NOP = '0;

  function automatic ex_mem_ctrl_t id_ex_to_ex_mem(input id_ex_ctrl_t c);
    ex_mem_ctrl_t r;
    r.rw  = c.rw;
    r.mem = c.mem;
    r.wr  = c.wr;
    return r;
  endfunction

  function automatic mem_wb_ctrl_t ex_mem_to_mem_wb(input ex_mem_ctrl_t c);
    mem_wb_ctrl_t r;
    r.rw = c.rw;
    r.wr = c.wr;
    return r;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: main entry plus skid entry, valid/ready
// handshake, flush-to-bubble. Optional stall counter: PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W   = ID_EX_DATA_W,
  parameter int unsigned       CTRL_W   = ID_EX_CTRL_W,
  parameter logic [CTRL_W-1:0] NOP_CTRL = {CTRL_W{1'b0}}
`ifdef PIPE_STAGE_STALL_CNT_EN
  , parameter int unsigned     CNT_W    = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  logic              main_v_q,   main_v_d;
  logic [DATA_W-1:0] main_dat_q, main_dat_d;
  logic [CTRL_W-1:0] main_ctl_q, main_ctl_d;
  logic              skid_v_q,   skid_v_d;
  logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
  logic [CTRL_W-1:0] skid_ctl_q, skid_ctl_d;
  logic              in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;

  logic acc_c;
  logic main_free_c;

  assign acc_c       = in_valid & in_ready_q;
  assign main_free_c = out_ready | ~main_v_q;

  // Next-state: flush kills both entries; otherwise main refills from skid first.
  always_comb begin
    main_v_d   = main_v_q;
    main_dat_d = main_dat_q;
    main_ctl_d = main_ctl_q;
    skid_v_d   = skid_v_q;
    skid_dat_d = skid_dat_q;
    skid_ctl_d = skid_ctl_q;

    if (flush) begin
      main_v_d   = 1'b0;
      skid_v_d   = 1'b0;
      main_ctl_d = NOP_CTRL;
      skid_ctl_d = NOP_CTRL;
    end else if (main_free_c) begin
      if (skid_v_q) begin
        main_v_d   = 1'b1;
        main_dat_d = skid_dat_q;
        main_ctl_d = skid_ctl_q;
        skid_v_d   = 1'b0;
      end else if (acc_c) begin
        main_v_d   = 1'b1;
        main_dat_d = in_data;
        main_ctl_d = in_ctrl;
      end else begin
        main_v_d   = 1'b0;
      end
    end else if (acc_c) begin
      skid_v_d   = 1'b1;
      skid_dat_d = in_data;
      skid_ctl_d = in_ctrl;
    end

    // Ready drops only while the skid entry is occupied.
    in_ready_d = ~skid_v_d;
    out_ctrl_d = main_v_d ? main_ctl_d : NOP_CTRL;
  end

  // Reset also holds in_ready low for the first cycle after it is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_v_q   <= 1'b0;
      main_dat_q <= '0;
      main_ctl_q <= NOP_CTRL;
      skid_v_q   <= 1'b0;
      skid_dat_q <= '0;
      skid_ctl_q <= NOP_CTRL;
      in_ready_q <= 1'b0;
      out_ctrl_q <= NOP_CTRL;
    end else begin
      main_v_q   <= main_v_d;
      main_dat_q <= main_dat_d;
      main_ctl_q <= main_ctl_d;
      skid_v_q   <= skid_v_d;
      skid_dat_q <= skid_dat_d;
      skid_ctl_q <= skid_ctl_d;
      in_ready_q <= in_ready_d;
      out_ctrl_q <= out_ctrl_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_v_q;
  assign out_data  = main_dat_q;
  assign out_ctrl  = out_ctrl_q;

`ifdef PIPE_STAGE_STALL_CNT_EN
  // Counts cycles where a bundle is presented but not taken; flush leaves it alone.
  logic stall_inc_c;

  assign stall_inc_c = main_v_q & ~out_ready;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .clear_i (reset),
    .inc_i   (stall_inc_c),
    .cnt_o   (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed steps plus random traffic,
// checked every cycle against a two-deep FIFO reference model.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 25;
  localparam logic [CW-1:0] NOP = 25'h15A5A5A;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [3:0]    stall_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W   (DW),
    .CTRL_W   (CW),
    .NOP_CTRL (NOP)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .CNT_W  (4)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } item_t;

  // Reference: up to two bundles in flight, head is what the output shows.
  item_t         mq[$];
  bit            m_rstq;
  logic [DW-1:0] m_held;
  int            m_stall;
  bit            last_acc;
  int            total;
  int            bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive, check outputs against the model, clock, update the model.
  task automatic step(input bit vld, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input bit ordy, input bit fl, input bit rst);
    bit    exp_v;
    bit    exp_rdy;
    bit    fire;
    item_t it;
    in_valid  = vld;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    exp_v   = (mq.size() > 0);
    exp_rdy = (mq.size() < 2) && !m_rstq;
    chk("out_valid", 64'(out_valid), 64'(exp_v));
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (exp_v) begin
      chk("out_data", 64'(out_data), 64'(mq[0].d));
      chk("out_ctrl", 64'(out_ctrl), 64'(mq[0].c));
    end else begin
      chk("idle_data", 64'(out_data), 64'(m_held));
      chk("idle_ctrl", 64'(out_ctrl), 64'(NOP));
    end
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    last_acc = vld && exp_rdy;
    fire     = exp_v && ordy;
    it.d     = d;
    it.c     = c;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_rstq  = 1'b1;
      m_held  = '0;
      m_stall = 0;
      last_acc = 1'b0;
    end else begin
      m_rstq = 1'b0;
      if (exp_v && !ordy && m_stall < 15) m_stall++;
      if (fl) begin
        mq.delete();
        last_acc = 1'b0;
      end else begin
        if (fire) void'(mq.pop_front());
        if (last_acc) mq.push_back(it);
      end
      if (mq.size() > 0) m_held = mq[0].d;
    end
    @(negedge clk);
  endtask

  initial begin
    int sent;
    total    = 0;
    bad      = 0;
    m_rstq   = 1'b1;
    m_held   = '0;
    m_stall  = 0;
    last_acc = 1'b0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
    @(negedge clk);

    // 1: reset for two cycles, then stream 1..4 with out_ready high.
    step(0, '0, '0, 1, 0, 1);
    step(0, '0, '0, 1, 0, 1);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_ctrl", 64'(out_ctrl), 64'(NOP));
    chk("rst_out_data", 64'(out_data), 64'(0));
    sent = 0;
    while (sent < 4) begin
      step(1, DW'(sent + 1), CW'(sent + 16), 1, 0, 0);
      if (last_acc) sent++;
    end
    chk("stream_last", 64'(out_data), 64'(4));
    step(0, '0, '0, 1, 0, 0);
    step(0, '0, '0, 1, 0, 0);

    // 2: back-pressure for three cycles with A, B, C offered.
    step(1, 32'hA, 25'h0A, 1, 0, 0);
    step(1, 32'hB, 25'h0B, 0, 0, 0);
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    chk("bp_head", 64'(out_data), 64'(32'hA));
    step(1, 32'hC, 25'h0C, 0, 0, 0);
    step(1, 32'hC, 25'h0C, 0, 0, 0);
    step(1, 32'hC, 25'h0C, 1, 0, 0);
    chk("bp_release_b", 64'(out_data), 64'(32'hB));
    step(1, 32'hC, 25'h0C, 1, 0, 0);
    chk("bp_release_c", 64'(out_data), 64'(32'hC));
    step(0, '0, '0, 1, 0, 0);
    step(0, '0, '0, 1, 0, 0);

    // 3: flush with main=A and skid=B while C is offered; then flush discards an accepted D.
    step(1, 32'h1A, 25'h1A, 1, 0, 0);
    step(1, 32'h1B, 25'h1B, 0, 0, 0);
    step(1, 32'h1C, 25'h1C, 0, 1, 0);
    chk("fl_out_valid", 64'(out_valid), 64'(0));
    chk("fl_out_ctrl", 64'(out_ctrl), 64'(NOP));
    chk("fl_in_ready", 64'(in_ready), 64'(1));
    step(0, '0, '0, 1, 0, 0);
    step(1, 32'h2A, 25'h2A, 1, 0, 0);
    step(1, 32'h2D, 25'h2D, 0, 1, 0);
    step(0, '0, '0, 1, 0, 0);
    step(0, '0, '0, 1, 0, 0);

    // 4: flush and reset together in the middle of a stall.
    step(1, 32'h3E, 25'h3E, 1, 0, 0);
    step(0, '0, '0, 0, 0, 0);
    step(0, '0, '0, 0, 0, 0);
    step(1, 32'h3F, 25'h3F, 0, 1, 1);
    chk("fr_out_valid", 64'(out_valid), 64'(0));
    chk("fr_in_ready", 64'(in_ready), 64'(0));
    chk("fr_out_data", 64'(out_data), 64'(0));
    chk("fr_out_ctrl", 64'(out_ctrl), 64'(NOP));
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("fr_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
    step(0, '0, '0, 1, 0, 0);

    // 5: random traffic with occasional flush.
    for (int i = 0; i < 1000; i++) begin
      step($urandom_range(0, 3) != 0, DW'($urandom), CW'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0, 0);
    end
    for (int i = 0; i < 4; i++) step(0, '0, '0, 1, 0, 0);

`ifdef PIPE_STAGE_STALL_CNT_EN
    // 6: stall counter saturates at 15.
    step(0, '0, '0, 1, 0, 1);
    step(0, '0, '0, 1, 0, 0);
    step(1, 32'h55, 25'h55, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, '0, '0, 0, 0, 0);
    chk("sat_cnt", 64'(stall_cnt), 64'(15));
    step(0, '0, '0, 0, 1, 0);
    step(0, '0, '0, 1, 0, 0);
    chk("sat_hold", 64'(stall_cnt), 64'(15));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
